// File: rtl/piso_byte_serializer_if.sv
// piso_byte_serializer_if
//   Bundles the word-side and byte-side handshakes of the PISO byte serializer.
//   Signals:
//     parallel_in / in_valid / in_ready     word input handshake
//     serial_out / out_valid / out_ready    byte output handshake
//     out_first / out_last                  byte 0 / byte NBYTES-1 markers
//     done                                  one-cycle pulse after a word's last byte
//     busy                                  word in flight
//   Modports: master = source of words and sink of bytes, slave = the serializer.
interface piso_byte_serializer_if #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned BYTE_W = 8
);
  logic [WORD_W-1:0] parallel_in;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] serial_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_first;
  logic              out_last;
  logic              done;
  logic              busy;

  modport master (
    output parallel_in, in_valid, out_ready,
    input  in_ready, serial_out, out_valid, out_first, out_last, done, busy
  );

  modport slave (
    input  parallel_in, in_valid, out_ready,
    output in_ready, serial_out, out_valid, out_first, out_last, done, busy
  );
endinterface

// File: rtl/piso_byte_serializer.sv
// piso_byte_serializer
//   Takes one WORD_W-bit word over a valid/ready handshake and emits it as
//   WORD_W/BYTE_W bytes on a valid/ready byte stream, flagging the first and
//   last byte and pulsing done once the last byte has been accepted. A new
//   word can be taken in the same cycle the last byte leaves, so back-to-back
//   words stream with no bubble.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   piso_byte_serializer_if.slave (word in, byte out, done, busy)
module piso_byte_serializer #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned BYTE_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  piso_byte_serializer_if.slave bus
);

  localparam int unsigned NBYTES = WORD_W / BYTE_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_next;
  logic [BYTE_W-1:0] byte_cur;
  logic [CNT_W-1:0]  count;
  logic              out_valid_q;
  logic              done_q;
  logic              xfer;
  logic              last_xfer;
  logic              accept;

  // The outgoing byte always sits at one end of the shift register; each
  // transfer moves the next byte into that slot and zero-fills the far end.
  if (MSB_FIRST) begin : g_msb
    assign byte_cur  = sreg[WORD_W-1 -: BYTE_W];
    assign sreg_next = {sreg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
  end else begin : g_lsb
    assign byte_cur  = sreg[BYTE_W-1:0];
    assign sreg_next = {{BYTE_W{1'b0}}, sreg[WORD_W-1:BYTE_W]};
  end

  assign xfer      = out_valid_q && bus.out_ready;
  assign last_xfer = xfer && (count == LAST_IDX);
  // Ready while idle, or in the cycle the last byte leaves so the next word
  // loads without a gap. Held low during reset since nothing can be taken.
  assign bus.in_ready = !rst && ((state == IDLE) || last_xfer);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= last_xfer;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg        <= bus.parallel_in;
            count       <= '0;
            out_valid_q <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            count <= '0;
            if (accept) begin
              sreg <= bus.parallel_in;
            end else begin
              sreg        <= sreg_next;
              out_valid_q <= 1'b0;
              state       <= IDLE;
            end
          end else if (xfer) begin
            sreg  <= sreg_next;
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.serial_out = byte_cur;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_first  = out_valid_q && (count == '0);
  assign bus.out_last   = out_valid_q && (count == LAST_IDX);
  assign bus.done       = done_q;
  assign bus.busy       = (state == SHIFT);

endmodule

// File: tb/tb_piso_byte_serializer.sv
module tb_piso_byte_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   mon_en;

  piso_byte_serializer_if #(.WORD_W(64), .BYTE_W(8)) bus_m ();
  piso_byte_serializer_if #(.WORD_W(64), .BYTE_W(8)) bus_l ();

  piso_byte_serializer #(.WORD_W(64), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_byte_serializer #(.WORD_W(64), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       first;
    logic       last;
  } exp_t;

  typedef struct {
    logic [63:0] word;
    logic [7:0]  stall_mask;   // bit k: hold out_ready low 3 cycles on byte k
    int          exp_done_cyc; // cycles from accept edge to done
  } vec_t;

  exp_t        exp_q[$];
  logic [63:0] lsb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for the MSB-first instance: bytes expected are pushed on accept
  // and popped on each transfer; done is expected the cycle after a last byte.
  initial begin : mon_m
    bit          done_pend;
    bit          stall_prev;
    logic [7:0]  prev_b;
    logic        prev_f;
    logic        prev_l;
    logic [63:0] tmp;
    exp_t        e;
    done_pend  = 1'b0;
    stall_prev = 1'b0;
    prev_b = '0; prev_f = 1'b0; prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          exp_q.delete();
          done_pend  = 1'b0;
          stall_prev = 1'b0;
        end else begin
          chk("done_pulse", 64'(bus_m.done), 64'(done_pend));
          if (stall_prev) begin
            chk("stall_hold_byte", 64'(bus_m.serial_out), 64'(prev_b));
            chk("stall_hold_first", 64'(bus_m.out_first), 64'(prev_f));
            chk("stall_hold_last", 64'(bus_m.out_last), 64'(prev_l));
          end
          done_pend = 1'b0;
          if (bus_m.out_valid === 1'b1 && bus_m.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_byte: got %h expected no byte", bus_m.serial_out);
            end else begin
              e = exp_q.pop_front();
              chk("byte", 64'(bus_m.serial_out), 64'(e.b));
              chk("first", 64'(bus_m.out_first), 64'(e.first));
              chk("last", 64'(bus_m.out_last), 64'(e.last));
              done_pend = e.last;
            end
          end
          stall_prev = (bus_m.out_valid === 1'b1) && (bus_m.out_ready !== 1'b1);
          prev_b = bus_m.serial_out;
          prev_f = bus_m.out_first;
          prev_l = bus_m.out_last;
          if (bus_m.in_valid === 1'b1 && bus_m.in_ready === 1'b1) begin
            for (int k = 0; k < 8; k++) begin
              tmp = bus_m.parallel_in >> (64 - 8 * (k + 1));
              e.b = tmp[7:0];
              e.first = (k == 0);
              e.last  = (k == 7);
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  end

  // Receiver model for the LSB-first instance: reassembles bytes into a word
  // and compares against the word that was accepted.
  initial begin : mon_l
    int          lk;
    logic [63:0] asm_w;
    logic [63:0] tmp;
    lk = 0;
    asm_w = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          lsb_q.delete();
          lk = 0;
          asm_w = '0;
        end else begin
          if (bus_l.out_valid === 1'b1 && bus_l.out_ready === 1'b1) begin
            if (lsb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL lsb_spurious_byte: got %h expected no byte", bus_l.serial_out);
            end else begin
              tmp = lsb_q[0] >> (8 * lk);
              chk("lsb_byte", 64'(bus_l.serial_out), 64'(tmp[7:0]));
              chk("lsb_first", 64'(bus_l.out_first), 64'(lk == 0));
              chk("lsb_last", 64'(bus_l.out_last), 64'(lk == 7));
              asm_w = asm_w | (64'(bus_l.serial_out) << (8 * lk));
              if (lk == 7) begin
                chk("lsb_reassembled", asm_w, lsb_q.pop_front());
                asm_w = '0;
                lk = 0;
              end else begin
                lk++;
              end
            end
          end
          if (bus_l.in_valid === 1'b1 && bus_l.in_ready === 1'b1)
            lsb_q.push_back(bus_l.parallel_in);
        end
      end
    end
  end

  // Offer a word, then drain it with the given stall pattern and time done.
  task automatic run_word(input logic [63:0] w, input logic [7:0] mask, input int exp_cyc);
    int k;
    int stall;
    bit got;
    @(posedge clk); #1;
    bus_m.parallel_in = w;
    bus_m.in_valid    = 1'b1;
    bus_m.out_ready   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_m.in_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    chk("accept", 64'(got), 64'd1);
    bus_m.in_valid = 1'b0;
    k = 0;
    stall = 0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      bus_m.out_ready = (k < 8) ? !(mask[k[2:0]] && stall < 3) : 1'b1;
      @(negedge clk);
      if (bus_m.done === 1'b1) begin
        got = 1'b1;
        chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        chk("busy_after_done", 64'(bus_m.busy), 64'd0);
      end
      if (bus_m.out_valid === 1'b1) begin
        if (bus_m.out_ready) begin
          k++;
          stall = 0;
        end else begin
          stall++;
        end
      end
      @(posedge clk); #1;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("bytes_transferred", 64'(k), 64'd8);
    bus_m.out_ready = 1'b1;
  endtask

  task automatic run_lsb(input logic [63:0] w);
    bit got;
    @(posedge clk); #1;
    bus_l.parallel_in = w;
    bus_l.in_valid    = 1'b1;
    bus_l.out_ready   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_l.in_ready === 1'b1) got = 1'b1;
      @(posedge clk); #1;
    end
    chk("lsb_accept", 64'(got), 64'd1);
    bus_l.in_valid = 1'b0;
    got = 1'b0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (bus_l.done === 1'b1) begin
        got = 1'b1;
        chk("lsb_done_cycle", 64'(cyc), 64'd9);
      end
      @(posedge clk); #1;
    end
    chk("lsb_done_seen", 64'(got), 64'd1);
  endtask

  initial begin : stim
    vec_t vecs[4];
    vecs[0] = '{64'h0102030405060708, 8'h00, 9};
    vecs[1] = '{64'h0102030405060708, 8'h24, 15};
    vecs[2] = '{64'hFFFF000080000001, 8'h81, 15};
    vecs[3] = '{64'h0000000000000000, 8'h10, 12};

    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst    = 1'b1;
    bus_m.parallel_in = '0; bus_m.in_valid = 1'b0; bus_m.out_ready = 1'b1;
    bus_l.parallel_in = '0; bus_l.in_valid = 1'b0; bus_l.out_ready = 1'b1;

    // Reset with random inputs: every output forced low.
    repeat (2) begin
      @(posedge clk); #1;
      bus_m.parallel_in = {$urandom, $urandom};
      bus_m.in_valid    = 1'($urandom);
      bus_m.out_ready   = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 64'(bus_m.out_valid), 64'd0);
      chk("rst_serial_out", 64'(bus_m.serial_out), 64'd0);
      chk("rst_first", 64'(bus_m.out_first), 64'd0);
      chk("rst_last", 64'(bus_m.out_last), 64'd0);
      chk("rst_done", 64'(bus_m.done), 64'd0);
      chk("rst_busy", 64'(bus_m.busy), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(bus_m.in_ready), 64'd1);
    chk("idle_out_valid", 64'(bus_m.out_valid), 64'd0);

    // Single words, with and without backpressure.
    for (int i = 0; i < 4; i++)
      run_word(vecs[i].word, vecs[i].stall_mask, vecs[i].exp_done_cyc);

    // Back-to-back words: 16 contiguous bytes, done 8 cycles apart.
    @(posedge clk); #1;
    bus_m.parallel_in = 64'hA0A1A2A3A4A5A6A7;
    bus_m.in_valid    = 1'b1;
    bus_m.out_ready   = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 64'(bus_m.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_m.parallel_in = 64'hB0B1B2B3B4B5B6B7;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc <= 16) chk("b2b_contiguous", 64'(bus_m.out_valid), 64'd1);
      chk("b2b_done", 64'(bus_m.done), 64'(cyc == 9 || cyc == 17));
      @(posedge clk); #1;
      if (cyc == 8) bus_m.in_valid = 1'b0;
    end

    // Reset after byte 04 drops the word without a done pulse.
    bus_m.parallel_in = 64'h0102030405060708;
    bus_m.in_valid    = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(bus_m.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_m.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(bus_m.out_valid), 64'd0);
    chk("mid_rst_done", 64'(bus_m.done), 64'd0);
    chk("mid_rst_busy", 64'(bus_m.busy), 64'd0);
    chk("mid_rst_serial_out", 64'(bus_m.serial_out), 64'd0);
    @(negedge clk);
    chk("mid_rst_no_done", 64'(bus_m.done), 64'd0);
    run_word(64'h0102030405060708, 8'h00, 9);

    // LSB-first instance feeding the reassembling receiver model.
    run_lsb(64'h0102030405060708);
    run_lsb({$urandom, $urandom});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("msb_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("lsb_queue_empty", 64'(lsb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
